// File: rtl/seg_display_decoder_if.sv
// seg_display_decoder_if: multiplexed 7-segment display inputs and captured-frame outputs
// of seg_display_decoder.
interface seg_display_decoder_if;
   logic [6:0]  segmentDisplay;
   logic [3:0]  an;
   logic        dp;
   logic [15:0] digits;
   logic [13:0] value;
   logic        valid;
   logic        frame_err;
   modport master (output segmentDisplay, an, dp, input digits, value, valid, frame_err);
   modport slave (input segmentDisplay, an, dp, output digits, value, valid, frame_err);
endinterface

// File: rtl/seg_display_decoder.sv
// seg_display_decoder: rebuilds a 4-digit BCD/binary frame by sniffing a multiplexed 7-seg display.
// Optional SEG_DECODER_DP_CHECK_EN: a lit decimal point at capture marks the frame erroneous.
module seg_display_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input logic clk,
   input logic reset,
   seg_display_decoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, HOLD, EMIT} state_t;
`ifdef SEG_DECODER_DP_CHECK_EN
   localparam int W = 12;
   logic [W-1:0] cur;
   logic dp_err;
   assign cur = {bus.an, bus.segmentDisplay, bus.dp};
   assign dp_err = ~bus.dp;
`else
   localparam int W = 11;
   logic [W-1:0] cur;
   logic dp_err;
   assign cur = {bus.an, bus.segmentDisplay};
   assign dp_err = 1'b0;
`endif
   state_t state;
   logic [7:0] cnt;
   logic [W-1:0] lat;
   logic [3:0] cap, err, sel;
   logic [15:0] dreg;
   logic [4:0] dv;
   logic [1:0] slot;
   logic an_ok, stable;
   function automatic logic [4:0] seg_dec(input logic [6:0] s);
      case (s)
         7'b1000000: seg_dec = 5'd0;
         7'b1111001: seg_dec = 5'd1;
         7'b0100100: seg_dec = 5'd2;
         7'b0110000: seg_dec = 5'd3;
         7'b0011001: seg_dec = 5'd4;
         7'b0010010: seg_dec = 5'd5;
         7'b0000010: seg_dec = 5'd6;
         7'b1111000: seg_dec = 5'd7;
         7'b0000000: seg_dec = 5'd8;
         7'b0010000: seg_dec = 5'd9;
         default:    seg_dec = 5'b10000;
      endcase
   endfunction
   always_comb begin
      an_ok = (bus.an == 4'b1110) || (bus.an == 4'b1101) || (bus.an == 4'b1011) || (bus.an == 4'b0111);
      sel = ~bus.an;
      slot = !bus.an[0] ? 2'd0 : !bus.an[1] ? 2'd1 : !bus.an[2] ? 2'd2 : 2'd3;
      dv = seg_dec(bus.segmentDisplay);
      stable = (cur == lat) && (cnt + 8'd1 == 8'(STABLE_CYCLES));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         lat <= '0;
         cap <= '0;
         err <= '0;
         dreg <= '0;
         bus.digits <= '0;
         bus.value <= '0;
         bus.valid <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         bus.valid <= 1'b0;
         case (state)
            IDLE: if (an_ok) begin
               lat <= cur;
               cnt <= 8'd1;
               state <= SETTLE;
            end
            SETTLE, HOLD: if (cur != lat) begin
               lat <= cur;
               cnt <= 8'd1;
               state <= an_ok ? SETTLE : IDLE;
            end else if (state == SETTLE) begin
               cnt <= cnt + 8'd1;
               if (stable) begin
                  dreg[{slot, 2'b00} +: 4] <= dv[3:0];
                  cap[slot] <= 1'b1;
                  err[slot] <= dv[4] | dp_err;
                  // completing the frame skips HOLD so valid lands one clock after this capture
                  state <= ((cap | sel) == 4'hf) ? EMIT : HOLD;
               end
            end
            EMIT: begin
               bus.digits <= dreg;
               bus.value <= 14'(dreg[15:12]) * 14'd1000 + 14'(dreg[11:8]) * 14'd100
                          + 14'(dreg[7:4]) * 14'd10 + 14'(dreg[3:0]);
               bus.frame_err <= |err;
               bus.valid <= 1'b1;
               cap <= '0;
               err <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seg_display_decoder.sv
// tb_seg_display_decoder: directed checks of frame capture, stability filtering, errors and reset.
module tb_seg_display_decoder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int passed = 0;
   int total = 0;
   int vcount = 0;
   int v0;
   seg_display_decoder_if bus ();
   seg_display_decoder #(.STABLE_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk) if (bus.valid === 1'b1) vcount <= vcount + 1;
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
   endtask
   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      bus.an = a;
      bus.segmentDisplay = s;
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      bus.an = 4'b1111;
      bus.segmentDisplay = 7'h7f;
      bus.dp = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      v0 = vcount;
   endtask
   initial begin
      bus.an = 4'b1111;
      bus.segmentDisplay = 7'h7f;
      bus.dp = 1'b1;
      do_reset();
      chk("rst_digits", 32'(bus.digits), 32'h0);
      chk("rst_value", 32'(bus.value), 32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_ferr", 32'(bus.frame_err), 32'd0);
      // basic frame 2135 with latency check on the final digit
      drive(4'b1110, 7'b0010010, 8);
      drive(4'b1101, 7'b0110000, 8);
      drive(4'b1011, 7'b1111001, 8);
      drive(4'b0111, 7'b0100100, 4);
      chk("lat_before", 32'(bus.valid), 32'd0);
      drive(4'b0111, 7'b0100100, 1);
      chk("lat_valid", 32'(bus.valid), 32'd1);
      chk("f2135_digits", 32'(bus.digits), 32'h2135);
      drive(4'b0111, 7'b0100100, 1);
      chk("lat_after", 32'(bus.valid), 32'd0);
      drive(4'b0111, 7'b0100100, 2);
      drive(4'b1111, 7'h7f, 3);
      chk("f2135_count", 32'(vcount - v0), 32'd1);
      chk("f2135_value", 32'(bus.value), 32'd2135);
      chk("f2135_ferr", 32'(bus.frame_err), 32'd0);
      // digits held one clock short of the stability window
      do_reset();
      drive(4'b1110, 7'b0010010, 3);
      drive(4'b1101, 7'b0110000, 3);
      drive(4'b1011, 7'b1111001, 3);
      drive(4'b0111, 7'b0100100, 3);
      drive(4'b1111, 7'h7f, 10);
      chk("short_count", 32'(vcount - v0), 32'd0);
      chk("short_digits", 32'(bus.digits), 32'h0);
      chk("short_value", 32'(bus.value), 32'd0);
      // illegal ones pattern
      do_reset();
      drive(4'b1110, 7'b1111111, 8);
      drive(4'b1101, 7'b0110000, 8);
      drive(4'b1011, 7'b1111001, 8);
      drive(4'b0111, 7'b0100100, 8);
      drive(4'b1111, 7'h7f, 3);
      chk("illegal_count", 32'(vcount - v0), 32'd1);
      chk("illegal_ferr", 32'(bus.frame_err), 32'd1);
      chk("illegal_digits", 32'(bus.digits), 32'h2130);
      chk("illegal_value", 32'(bus.value), 32'd2130);
      // reset mid-frame discards partial captures
      do_reset();
      drive(4'b1110, 7'b1111000, 8);
      drive(4'b1101, 7'b0010000, 8);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(4'b1011, 7'b0010000, 8);
      drive(4'b0111, 7'b0010000, 8);
      drive(4'b1111, 7'h7f, 3);
      chk("midrst_nopulse", 32'(vcount - v0), 32'd0);
      chk("midrst_digits", 32'(bus.digits), 32'h0);
      drive(4'b1110, 7'b0010000, 8);
      drive(4'b1101, 7'b0010000, 8);
      drive(4'b1111, 7'h7f, 3);
      chk("f9999_count", 32'(vcount - v0), 32'd1);
      chk("f9999_value", 32'(bus.value), 32'd9999);
      chk("f9999_digits", 32'(bus.digits), 32'h9999);
      // reset coinciding with EMIT suppresses the pulse
      do_reset();
      drive(4'b1110, 7'b0010010, 8);
      drive(4'b1101, 7'b0110000, 8);
      drive(4'b1011, 7'b1111001, 8);
      drive(4'b0111, 7'b0100100, 4);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("emitrst_valid", 32'(bus.valid), 32'd0);
      drive(4'b1111, 7'h7f, 3);
      chk("emitrst_count", 32'(vcount - v0), 32'd0);
      chk("emitrst_digits", 32'(bus.digits), 32'h0);
      // glitch restarts the count, idle anodes ignored, frame 0408
      do_reset();
      drive(4'b1110, 7'b0000000, 3);
      drive(4'b1110, 7'b1111001, 1);
      drive(4'b1110, 7'b0000000, 3);
      drive(4'b0000, 7'b0000000, 50);
      drive(4'b1101, 7'b1000000, 8);
      drive(4'b1111, 7'b1000000, 50);
      drive(4'b1011, 7'b0011001, 8);
      drive(4'b0111, 7'b1000000, 8);
      drive(4'b1111, 7'h7f, 5);
      chk("glitch_nocap", 32'(vcount - v0), 32'd0);
      drive(4'b1110, 7'b0000000, 8);
      drive(4'b1111, 7'h7f, 5);
      chk("f0408_count", 32'(vcount - v0), 32'd1);
      chk("f0408_value", 32'(bus.value), 32'd408);
      chk("f0408_digits", 32'(bus.digits), 32'h0408);
      chk("f0408_ferr", 32'(bus.frame_err), 32'd0);
      // lit decimal point during tens capture
      do_reset();
      drive(4'b1110, 7'b0010010, 8);
      bus.dp = 1'b0;
      drive(4'b1101, 7'b0110000, 8);
      bus.dp = 1'b1;
      drive(4'b1011, 7'b1111001, 8);
      drive(4'b0111, 7'b0100100, 8);
      drive(4'b1111, 7'h7f, 3);
      chk("dp_count", 32'(vcount - v0), 32'd1);
      chk("dp_digits", 32'(bus.digits), 32'h2135);
`ifdef SEG_DECODER_DP_CHECK_EN
      chk("dp_ferr", 32'(bus.frame_err), 32'd1);
`else
      chk("dp_ferr", 32'(bus.frame_err), 32'd0);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/seg_display_decoder.md
SEG_DISPLAY_DECODER -- requirements
Module: seg_display_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical clocks required before a digit is captured (legal range 2..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 segmentDisplay  input  7  active-low segments {g,f,e,d,c,b,a}, bit 6 = g.
REQ-005 an  input  4  active-low anode select; an[0] = ones, an[3] = thousands.
REQ-006 dp  input  1  active-low decimal point.
REQ-007 digits  output  16  captured BCD frame {thousands,hundreds,tens,ones}.
REQ-008 value  output  14  binary equivalent of digits, 0..9999.
REQ-009 valid  output  1  one-cycle pulse when digits/value update.
REQ-010 frame_err  output  1  held with each frame; 1 = frame contained an illegal pattern.

Function
REQ-011 Digit select legal only when an is one-hot-low (1110, 1101, 1011, 0111); any other an value (incl. 1111, 0000) is idle.
REQ-012 Decode table (segmentDisplay -> digit): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9; all other patterns illegal.
REQ-013 FSM states IDLE, SETTLE, HOLD, EMIT; reset state IDLE.
REQ-014 IDLE -> SETTLE when an is legal; stability counter loads 1 and {an,segmentDisplay} is latched.
REQ-015 SETTLE: counter increments each clock while {an,segmentDisplay} equals latched value; any change reloads latch and counter to 1 (stays SETTLE if new an legal, else IDLE).
REQ-016 SETTLE -> HOLD on the clock the counter reaches STABLE_CYCLES; that clock writes decoded digit into slot selected by an, sets slot's captured flag, sets slot's error flag if pattern illegal (digit stored as 0).
REQ-017 HOLD: no further capture until {an,segmentDisplay} changes; then -> SETTLE (legal an) or IDLE.
REQ-018 Recapture of an already-captured slot before frame completion overwrites digit and error flag.
REQ-019 When all four captured flags are set, next state is EMIT regardless of inputs; EMIT lasts exactly one clock, then -> IDLE.
REQ-020 In EMIT: digits and value register the frame, value = th*1000 + h*100 + t*10 + o computed with constant multiplies, frame_err = OR of slot error flags, valid = 1; all captured/error flags clear.
REQ-021 Latency: valid asserts 1 clock after the capture clock completing the frame; digits, value, frame_err valid in the same cycle as valid and held until next EMIT.
REQ-022 Inputs are assumed synchronous to clk; no internal synchronizer.

Reset
REQ-023 Reset forces state IDLE, counter 0, all captured/error flags 0, digits 16'h0000, value 0, valid 0, frame_err 0.
REQ-024 Reset asserted mid-frame discards all partial captures; first frame after reset requires four fresh captures.
REQ-025 Reset has priority over EMIT occurring in the same clock; no valid pulse is produced.

Configuration
REQ-026 Macro SEG_DECODER_DP_CHECK_EN defined: dp = 0 (lit) at a capture clock sets that slot's error flag; dp is part of the stability comparison.
REQ-027 Macro SEG_DECODER_DP_CHECK_EN undefined: dp ignored entirely; no logic depends on it.

Verification
REQ-028 Reset, then drive an=1110/seg=0010010, 1101/0110000, 1011/1111001, 0111/0100100, each 8 clocks -> single valid pulse, digits=16'h2135, value=2135, frame_err=0.
REQ-029 Same sequence with each digit held only STABLE_CYCLES-1 clocks -> no valid, outputs remain reset values.
REQ-030 Frame with ones pattern 1111111 -> valid pulse, frame_err=1, digits[3:0]=0.
REQ-031 Capture ones=7, tens=9, then assert reset 1 clock, then full frame 9999 -> exactly one valid, value=9999, no stale digits.
REQ-032 an=0000 and an=1111 for 50 clocks between digits, plus one-clock glitch on segmentDisplay mid-digit -> glitch restarts count, idle periods ignored, frame 0408 decodes value=408.
REQ-033 With SEG_DECODER_DP_CHECK_EN defined, dp=0 during tens capture -> frame_err=1; undefined -> frame_err=0 for identical stimulus.
